apb_led_pwm_ctrl: RTL and testbench

//  APB-slave LED controller for LED_NUM channels, sitting on the peripheral APB alongside other register slaves.

---
 rtl/apb_led_pwm_ctrl.sv | 164 ++++++++++++++++
 tb/tb_apb_led_pwm_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_led_pwm_ctrl.sv
// apb_led_pwm_ctrl
//   APB register slave driving LED_NUM LED channels. Each channel is static,
//   blinking, PWM-dimmed or blinking+dimmed. A shared prescaler produces a
//   tick that advances one blink timer and one PWM counter.
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   apb_req/psel/enab/rw   bus request, select, access phase, 0=read 1=write
//   apb_addr               byte address, [4:2] selects the register
//   apb_datai / apb_datao  write data / read data (valid while apb_ack=1)
//   apb_ack                one-cycle transfer acknowledge
//   led                    registered LED pins (inverted when ACTIVE_LOW=1)
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_led_pwm_ctrl #(
    parameter int unsigned LED_NUM    = 4,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned PRE_W      = 16,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       apb_req,
    input  logic                       apb_psel,
    input  logic                       apb_rw,
    input  logic [`ADDR_WIDTH-1:0]     apb_addr,
    input  logic                       apb_enab,
    input  logic [`APB_DATA_WIDTH-1:0] apb_datai,
    output logic [`APB_DATA_WIDTH-1:0] apb_datao,
    output logic                       apb_ack,
    output logic [LED_NUM-1:0]         led
);

    localparam int unsigned DW = `APB_DATA_WIDTH;

    logic [LED_NUM-1:0]  out_q, out_d, blink_q, blink_d, pwmen_q, pwmen_d;
    logic [PRE_W-1:0]    pre_q, pre_d, pre_cnt_q, pre_cnt_d;
    logic [15:0]         period_q, period_d, bcnt_q, bcnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d, pwm_cnt_q, pwm_cnt_d;
    logic                phase_q, phase_d;
    logic                ack_q, ack_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [LED_NUM-1:0]  led_q, led_d;

    logic                access, tick, pwm_on, clr;
    logic [2:0]          idx;
    logic [DW-1:0]       rd_mux;
    logic [LED_NUM-1:0]  lit;

    logic unused_bits;
    assign unused_bits = ^{apb_addr, apb_datai};

    always_comb begin
        idx    = apb_addr[4:2];
        access = apb_req & apb_psel & apb_enab & ~ack_q;

        // read value reflects state before any write in the same access
        rd_mux = '0;
        case (idx)
            3'd0: rd_mux[LED_NUM-1:0]  = out_q;
            3'd1: rd_mux[LED_NUM-1:0]  = blink_q;
            3'd2: rd_mux[LED_NUM-1:0]  = pwmen_q;
            3'd3: rd_mux[PRE_W-1:0]    = pre_q;
            3'd4: rd_mux[15:0]         = period_q;
            3'd5: rd_mux[PWM_BITS-1:0] = duty_q;
            3'd6: begin
                rd_mux[16]             = phase_q;
                rd_mux[PWM_BITS-1:0]   = pwm_cnt_q;
            end
            default: rd_mux = '0;
        endcase

        ack_d   = access;
        rdata_d = access ? rd_mux : '0;

        out_d    = out_q;
        blink_d  = blink_q;
        pwmen_d  = pwmen_q;
        pre_d    = pre_q;
        period_d = period_q;
        duty_d   = duty_q;
        clr      = 1'b0;

        if (access && apb_rw) begin
            case (idx)
                3'd0: out_d    = apb_datai[LED_NUM-1:0];
                3'd1: blink_d  = apb_datai[LED_NUM-1:0];
                3'd2: pwmen_d  = apb_datai[LED_NUM-1:0];
                3'd3: begin pre_d    = apb_datai[PRE_W-1:0];    clr = 1'b1; end
                3'd4: begin period_d = apb_datai[15:0];         clr = 1'b1; end
                3'd5: begin duty_d   = apb_datai[PWM_BITS-1:0]; clr = 1'b1; end
                default: ;
            endcase
        end

        tick      = (pre_cnt_q == pre_q);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;
        pwm_cnt_d = pwm_cnt_q;
        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            if (bcnt_q == period_q) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + 16'd1;
            end
        end

        // a timing-register write overrides any tick in the same cycle
        if (clr) begin
            pre_cnt_d = '0;
            bcnt_d    = '0;
            pwm_cnt_d = '0;
            phase_d   = 1'b1;
        end

        pwm_on = (pwm_cnt_q < duty_q);
        lit    = out_q & (~blink_q | {LED_NUM{phase_q}}) & (~pwmen_q | {LED_NUM{pwm_on}});
        led_d  = lit ^ {LED_NUM{ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q     <= '0;
            blink_q   <= '0;
            pwmen_q   <= '0;
            pre_q     <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            pre_cnt_q <= '0;
            bcnt_q    <= '0;
            pwm_cnt_q <= '0;
            phase_q   <= 1'b1;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            led_q     <= {LED_NUM{ACTIVE_LOW}};
        end else begin
            out_q     <= out_d;
            blink_q   <= blink_d;
            pwmen_q   <= pwmen_d;
            pre_q     <= pre_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            pre_cnt_q <= pre_cnt_d;
            bcnt_q    <= bcnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            phase_q   <= phase_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            led_q     <= led_d;
        end
    end

    assign apb_ack   = ack_q;
    assign apb_datao = rdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_apb_led_pwm_ctrl.sv
// Testbench for apb_led_pwm_ctrl: an active-high and an active-low instance
// share one bus; both are checked every cycle against an arithmetic model
// that derives counter state from the number of cycles since the last clear.
module tb_apb_led_pwm_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, apb_req, apb_psel, apb_rw, apb_enab;
    logic [31:0] apb_addr, apb_datai, apb_datao, datao_al;
    logic        apb_ack, ack_al;
    logic [3:0]  led, led_al;

    int unsigned total = 0;
    int unsigned bad   = 0;

    apb_led_pwm_ctrl #(.LED_NUM(4), .PWM_BITS(8), .PRE_W(16), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .resetn(resetn), .apb_req(apb_req), .apb_psel(apb_psel), .apb_rw(apb_rw),
        .apb_addr(apb_addr), .apb_enab(apb_enab), .apb_datai(apb_datai),
        .apb_datao(apb_datao), .apb_ack(apb_ack), .led(led));

    apb_led_pwm_ctrl #(.LED_NUM(4), .PWM_BITS(8), .PRE_W(16), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .resetn(resetn), .apb_req(apb_req), .apb_psel(apb_psel), .apb_rw(apb_rw),
        .apb_addr(apb_addr), .apb_enab(apb_enab), .apb_datai(apb_datai),
        .apb_datao(datao_al), .apb_ack(ack_al), .led(led_al));

    // ---------------- reference model ----------------
    logic [3:0]  m_out, m_blink, m_pwmen;
    logic [15:0] m_pre, m_period;
    logic [7:0]  m_duty;
    int unsigned m_k;      // clock edges since the last counter clear
    logic        m_ack;
    logic [31:0] m_rdata;
    logic [3:0]  m_led;

    function automatic int unsigned m_ticks();
        return m_k / (32'(m_pre) + 32'd1);
    endfunction

    function automatic logic m_phase();
        return ((m_ticks() / (32'(m_period) + 32'd1)) % 2) == 0;
    endfunction

    function automatic logic [7:0] m_pwm();
        return 8'(m_ticks() % 256);
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0: return {28'b0, m_out};
            3'd1: return {28'b0, m_blink};
            3'd2: return {28'b0, m_pwmen};
            3'd3: return {16'b0, m_pre};
            3'd4: return {16'b0, m_period};
            3'd5: return {24'b0, m_duty};
            3'd6: return {15'b0, m_phase(), 8'b0, m_pwm()};
            default: return 32'b0;
        endcase
    endfunction

    always @(posedge clk) begin : model_upd
        logic [3:0] nl;
        logic       acc;
        if (!resetn) begin
            m_out = 0; m_blink = 0; m_pwmen = 0; m_pre = 0; m_period = 0; m_duty = 0;
            m_k = 0; m_ack = 0; m_rdata = 0; m_led = 0;
        end else begin
            nl = m_out & (~m_blink | {4{m_phase()}}) & (~m_pwmen | {4{m_pwm() < m_duty}});
            acc = apb_req & apb_psel & apb_enab & ~m_ack;
            m_rdata = acc ? model_read(apb_addr[4:2]) : 32'b0;
            m_ack = acc;
            m_k = m_k + 1;
            if (acc && apb_rw) begin
                case (apb_addr[4:2])
                    3'd0: m_out    = apb_datai[3:0];
                    3'd1: m_blink  = apb_datai[3:0];
                    3'd2: m_pwmen  = apb_datai[3:0];
                    3'd3: begin m_pre    = apb_datai[15:0]; m_k = 0; end
                    3'd4: begin m_period = apb_datai[15:0]; m_k = 0; end
                    3'd5: begin m_duty   = apb_datai[7:0];  m_k = 0; end
                    default: ;
                endcase
            end
            m_led = nl;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("led", {28'b0, led}, {28'b0, m_led});
        chk("led_al", {28'b0, led_al}, {28'b0, ~m_led});
        chk("ack", {31'b0, apb_ack}, {31'b0, m_ack});
        chk("ack_al", {31'b0, ack_al}, {31'b0, m_ack});
        chk("datao", apb_datao, m_rdata);
        chk("datao_al", datao_al, m_rdata);
    endtask

    task automatic idle();
        apb_req = 0; apb_psel = 0; apb_enab = 0; apb_rw = 0;
    endtask

    task automatic xfer(input bit rw, input logic [2:0] idx, input logic [31:0] d,
                        input bit hold, output logic [31:0] rd);
        logic [31:0] a;
        a = $urandom();
        a[4:2] = idx;
        apb_req = 1; apb_psel = 1; apb_enab = 1; apb_rw = rw; apb_addr = a; apb_datai = d;
        step();
        chk("ack_hi", {31'b0, apb_ack}, 32'd1);
        rd = apb_datao;
        if (!hold) idle();
        step();
        chk("ack_lo", {31'b0, apb_ack}, 32'd0);
        idle();
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        logic [31:0] rd;
        xfer(1'b1, idx, d, 1'b0, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] rd;
        xfer(1'b0, idx, 32'b0, 1'b0, rd);
        chk(tag, rd, exp);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        logic [31:0] rd;
        logic [31:0] d;
        bit          v [0:1023];
        int unsigned ones, viol, hi;

        resetn = 0; apb_addr = 0; apb_datai = 0; idle();
        repeat (3) step();
        chk("rst_led", {28'b0, led}, 32'h0);
        chk("rst_led_al", {28'b0, led_al}, 32'hF);
        chk("rst_ack", {31'b0, apb_ack}, 32'h0);

        // reset values: STAT first so the counters are still at their cleared state
        resetn = 1;
        rd_chk("rst_stat", 3'd6, 32'h0001_0000);
        for (int i = 0; i < 8; i++)
            if (i != 6) rd_chk("rst_reg", 3'(i), 32'h0);

        // static mode
        wr(3'd0, 32'hFFFF_FFFA);
        chk("static_led", {28'b0, led}, 32'hA);
        rd_chk("out_rb", 3'd0, 32'hA);

        // blink: 4 on / 4 off
        wr(3'd3, 32'd0); wr(3'd4, 32'd3); wr(3'd1, 32'd1); wr(3'd0, 32'd1);
        ones = 0; viol = 0; hi = 0;
        for (int t = 0; t < 32; t++) begin
            step();
            v[t] = led[0];
            ones += 32'(led[0]);
            hi += 32'(|led[3:1]);
        end
        for (int t = 0; t < 28; t++) if (v[t] == v[t+4]) viol++;
        chk("blink_ones", ones, 32'd16);
        chk("blink_shape", viol, 32'd0);
        chk("blink_upper", hi, 32'd0);

        // PWM: 128 of every 512 clk
        wr(3'd1, 32'd0); wr(3'd3, 32'd1); wr(3'd5, 32'd64); wr(3'd2, 32'd1);
        ones = 0; viol = 0;
        for (int t = 0; t < 1024; t++) begin
            step();
            v[t] = led[0];
            if (t < 512) ones += 32'(led[0]);
        end
        for (int t = 0; t < 512; t++) if (v[t] != v[t+512]) viol++;
        chk("pwm_ones", ones, 32'd128);
        chk("pwm_period", viol, 32'd0);

        // DUTY write clears counters; DUTY=0 keeps the LED dark
        wr(3'd3, 32'd20);
        repeat (37) step();
        wr(3'd5, 32'd77);
        rd_chk("stat_clr", 3'd6, 32'h0001_0000);
        wr(3'd5, 32'd0);
        ones = 0;
        for (int t = 0; t < 300; t++) begin
            step();
            ones += 32'(led[0]);
        end
        chk("duty0", ones, 32'd0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                resetn = 0;
                if ($urandom_range(0, 1) == 1) begin
                    apb_req = 1; apb_psel = 1; apb_enab = 1; apb_rw = 1;
                    apb_addr = $urandom(); apb_datai = $urandom();
                end
                repeat ($urandom_range(1, 2)) step();
                resetn = 1;
                idle();
            end
            d = $urandom();
            case ($urandom_range(0, 2))
                0: d[15:0] = 16'($urandom_range(0, 3));
                1: d[15:0] = 16'($urandom_range(0, 7));
                default: ;
            endcase
            apb_req = 1'($urandom_range(0, 7) != 0);
            apb_psel = 1'($urandom_range(0, 7) != 0);
            if (apb_req && apb_psel)
                xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), d, 1'($urandom_range(0, 1)), rd);
            else begin
                apb_enab = 1; apb_rw = 1; apb_addr = $urandom(); apb_datai = d;
                step();
                idle();
            end
            repeat ($urandom_range(0, 3)) step();
        end

        // reset asserted during a write access
        wr(3'd2, 32'd0); wr(3'd1, 32'd0); wr(3'd0, 32'hF);
        apb_req = 1; apb_psel = 1; apb_enab = 1; apb_rw = 1;
        apb_addr = 32'h0; apb_datai = 32'h5;
        resetn = 0;
        step();
        chk("rstw_ack", {31'b0, apb_ack}, 32'h0);
        chk("rstw_led", {28'b0, led}, 32'h0);
        chk("rstw_led_al", {28'b0, led_al}, 32'hF);
        resetn = 1;
        idle();
        step();
        rd_chk("rstw_out", 3'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
